tx_resp_scheduler: RTL and testbench

- Arbitrates between the two response sources of the command system: a 2-byte ALU result and a 1-byte register-file read.
- Serializes the granted response into bytes and pushes them into the TX async FIFO write port, honouring FIFO_full backpressure.
- Sits between the system controller's response paths and the FIFO feeding the UART transmitter.
- Round-robin fairness between the two sources.

---
 rtl/tx_resp_scheduler.sv | 121 ++++++++++++
 tb/tb_tx_resp_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_scheduler.sv
// Round-robin scheduler serializing ALU (2-byte) and RF (1-byte) responses into the TX FIFO.
// Optional source-tag byte before each frame: define TX_RESP_TAG_EN.
module tx_resp_scheduler #(
   parameter int unsigned Data_width = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      alu_req,
   input  logic [2*Data_width-1:0]   alu_data,
   output logic                      alu_ack,
   input  logic                      rf_req,
   input  logic [Data_width-1:0]     rf_data,
   output logic                      rf_ack,
   input  logic                      FIFO_full,
   output logic [Data_width-1:0]     WR_DATA,
   output logic                      WR_INC,
   output logic                      busy
);

   localparam int unsigned DW = Data_width;
   localparam int unsigned CW = 2 * Data_width;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALU_LO = 3'd1,
      ALU_HI = 3'd2,
      RF_B   = 3'd3
`ifdef TX_RESP_TAG_EN
      ,
      TAG    = 3'd4
`endif
   } state_t;

   state_t          state;
   logic            ptr_alu;
   logic [CW-1:0]   cap;
`ifdef TX_RESP_TAG_EN
   logic            tag_alu;
`endif

   logic            grant_alu;
   logic            grant_rf;

   // Pointer only matters when both sources request in the same IDLE cycle
   assign grant_alu = alu_req && (!rf_req || ptr_alu);
   assign grant_rf  = rf_req && !grant_alu;

   assign busy   = (state != IDLE);
   assign WR_INC = (state != IDLE) && !FIFO_full;

   always_comb begin
      WR_DATA = '0;
      case (state)
         ALU_LO:  WR_DATA = cap[DW-1:0];
         ALU_HI:  WR_DATA = cap[CW-1:DW];
         RF_B:    WR_DATA = cap[DW-1:0];
`ifdef TX_RESP_TAG_EN
         TAG:     WR_DATA = tag_alu ? DW'(8'hF1) : DW'(8'hF2);
`endif
         default: WR_DATA = '0;
      endcase
   end

   // Send states advance only on an accepted write, so a stalled byte stays on WR_DATA
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         ptr_alu <= 1'b1;
         cap     <= '0;
         alu_ack <= 1'b0;
         rf_ack  <= 1'b0;
`ifdef TX_RESP_TAG_EN
         tag_alu <= 1'b0;
`endif
      end else begin
         alu_ack <= 1'b0;
         rf_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_alu) begin
                  cap     <= alu_data;
                  alu_ack <= 1'b1;
                  ptr_alu <= 1'b0;
`ifdef TX_RESP_TAG_EN
                  tag_alu <= 1'b1;
                  state   <= TAG;
`else
                  state   <= ALU_LO;
`endif
               end else if (grant_rf) begin
                  cap     <= CW'(rf_data);
                  rf_ack  <= 1'b1;
                  ptr_alu <= 1'b1;
`ifdef TX_RESP_TAG_EN
                  tag_alu <= 1'b0;
                  state   <= TAG;
`else
                  state   <= RF_B;
`endif
               end
            end
`ifdef TX_RESP_TAG_EN
            TAG: begin
               if (!FIFO_full) state <= tag_alu ? ALU_LO : RF_B;
            end
`endif
            ALU_LO: begin
               if (!FIFO_full) state <= ALU_HI;
            end
            ALU_HI: begin
               if (!FIFO_full) state <= IDLE;
            end
            RF_B: begin
               if (!FIFO_full) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Directed bench for tx_resp_scheduler; checks per-cycle ack/write/busy/data and the byte stream.
module tb_tx_resp_scheduler;

   logic        CLK = 1'b0;
   logic        RST;
   logic        alu_req;
   logic [15:0] alu_data;
   logic        alu_ack;
   logic        rf_req;
   logic [7:0]  rf_data;
   logic        rf_ack;
   logic        FIFO_full;
   logic [7:0]  WR_DATA;
   logic        WR_INC;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  wq[$];
   logic [11:0] obs;

   tx_resp_scheduler #(.Data_width(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .alu_req   (alu_req),
      .alu_data  (alu_data),
      .alu_ack   (alu_ack),
      .rf_req    (rf_req),
      .rf_data   (rf_data),
      .rf_ack    (rf_ack),
      .FIFO_full (FIFO_full),
      .WR_DATA   (WR_DATA),
      .WR_INC    (WR_INC),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   // {alu_ack, rf_ack, WR_INC, busy, WR_DATA}
   assign obs = {alu_ack, rf_ack, WR_INC, busy, WR_DATA};

   // Record every byte the FIFO accepts
   always @(posedge CLK) if (WR_INC === 1'b1) wq.push_back(WR_DATA);

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; alu_req = 1'b0; rf_req = 1'b0; FIFO_full = 1'b0;
      alu_data = 16'h0; rf_data = 8'h0;
      step(); step();
      compared++;
      if (obs !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_outputs: got %h want %h", obs, 12'h000);
      end
      RST = 1'b0;
      step();
      compared++;
      if (obs !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_idle: got %h want %h", obs, 12'h000);
      end
   endtask

   task automatic test_alu_only();
      logic [11:0] exp_c [3] = '{12'hBEF, 12'h3BE, 12'h000};
      wq.delete();
      alu_data = 16'hBEEF; alu_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 0) alu_req = 1'b0;
         compared++;
         if (obs !== exp_c[i]) begin
            mismatched++;
            $display("FAIL alu_only_cycle%0d: got %h want %h", i + 1, obs, exp_c[i]);
         end
      end
      compared++;
      if (wq.size() != 2 || wq[0] !== 8'hEF || wq[1] !== 8'hBE) begin
         mismatched++;
         $display("FAIL alu_only_stream: got %0d bytes want 2 (EF BE)", wq.size());
      end
   endtask

   task automatic test_rf_only();
      wq.delete();
      rf_data = 8'h5A; rf_req = 1'b1;
      step();
      rf_req = 1'b0;
      compared++;
      if (obs !== 12'h75A) begin
         mismatched++;
         $display("FAIL rf_only_cycle1: got %h want %h", obs, 12'h75A);
      end
      step();
      compared++;
      if (obs !== 12'h000) begin
         mismatched++;
         $display("FAIL rf_only_cycle2: got %h want %h", obs, 12'h000);
      end
      compared++;
      if (wq.size() != 1 || wq[0] !== 8'h5A) begin
         mismatched++;
         $display("FAIL rf_only_stream: got %0d bytes want 1 (5A)", wq.size());
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_q [5] = '{8'h34, 8'h12, 8'h77, 8'h34, 8'h12};
      wq.delete();
      for (int r = 0; r < 3; r++) begin
         alu_data = 16'h1234; rf_data = 8'h77;
         alu_req = 1'b1; rf_req = 1'b1;
         step();
         alu_req = 1'b0; rf_req = 1'b0;
         compared++;
         if (obs !== ((r % 2 == 0) ? 12'hB34 : 12'h777)) begin
            mismatched++;
            $display("FAIL rr_grant_round%0d: got %h want %h", r, obs,
                     (r % 2 == 0) ? 12'hB34 : 12'h777);
         end
         if (r % 2 == 0) begin
            step();
            compared++;
            if (obs !== 12'h312) begin
               mismatched++;
               $display("FAIL rr_hi_round%0d: got %h want %h", r, obs, 12'h312);
            end
         end
         step();
      end
      compared++;
      if (wq.size() != 5) begin
         mismatched++;
         $display("FAIL rr_stream_len: got %0d want 5", wq.size());
      end
      for (int i = 0; i < 5; i++) begin
         compared++;
         if (wq[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL rr_stream_byte%0d: got %h want %h", i, wq[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      wq.delete();
      alu_data = 16'hA1B2; alu_req = 1'b1; FIFO_full = 1'b1;
      step();
      alu_req = 1'b0;
      compared++;
      if (obs !== 12'h9B2) begin
         mismatched++;
         $display("FAIL bp_ack_cycle: got %h want %h", obs, 12'h9B2);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         compared++;
         if (obs !== 12'h1B2) begin
            mismatched++;
            $display("FAIL bp_stall%0d: got %h want %h", i, obs, 12'h1B2);
         end
      end
      step();
      FIFO_full = 1'b0;
      #1;
      compared++;
      if (obs !== 12'h3B2) begin
         mismatched++;
         $display("FAIL bp_release_lo: got %h want %h", obs, 12'h3B2);
      end
      step();
      compared++;
      if (obs !== 12'h3A1) begin
         mismatched++;
         $display("FAIL bp_release_hi: got %h want %h", obs, 12'h3A1);
      end
      step();
      compared++;
      if (obs !== 12'h000) begin
         mismatched++;
         $display("FAIL bp_done: got %h want %h", obs, 12'h000);
      end
      compared++;
      if (wq.size() != 2 || wq[0] !== 8'hB2 || wq[1] !== 8'hA1) begin
         mismatched++;
         $display("FAIL bp_stream: got %0d bytes want 2 (B2 A1)", wq.size());
      end
   endtask

   task automatic test_reset_midframe();
      alu_data = 16'hCAFE; alu_req = 1'b1;
      step();
      alu_req = 1'b0;
      step();
      compared++;
      if (obs !== 12'h3CA) begin
         mismatched++;
         $display("FAIL rst_in_hi_pre: got %h want %h", obs, 12'h3CA);
      end
      RST = 1'b1;
      step();
      compared++;
      if (obs !== 12'h000) begin
         mismatched++;
         $display("FAIL rst_abort: got %h want %h", obs, 12'h000);
      end
      RST = 1'b0;
      alu_data = 16'h1111; rf_data = 8'h22;
      alu_req = 1'b1; rf_req = 1'b1;
      step();
      alu_req = 1'b0; rf_req = 1'b0;
      compared++;
      if (obs !== 12'hB11) begin
         mismatched++;
         $display("FAIL rst_ptr_alu_first: got %h want %h", obs, 12'hB11);
      end
      step(); step();
      compared++;
      if (obs !== 12'h000) begin
         mismatched++;
         $display("FAIL rst_followup_idle: got %h want %h", obs, 12'h000);
      end
   endtask

`ifdef TX_RESP_TAG_EN
   task automatic test_tag();
      logic [11:0] exp_c [7] = '{12'h7F2, 12'h33C, 12'h000, 12'hBF1, 12'h302, 12'h301, 12'h000};
      logic [7:0]  exp_q [5] = '{8'hF2, 8'h3C, 8'hF1, 8'h02, 8'h01};
      wq.delete();
      rf_data = 8'h3C; alu_data = 16'h0102;
      rf_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         rf_req = 1'b0;
         alu_req = (i == 2);
         compared++;
         if (obs !== exp_c[i]) begin
            mismatched++;
            $display("FAIL tag_cycle%0d: got %h want %h", i, obs, exp_c[i]);
         end
      end
      compared++;
      if (wq.size() != 5) begin
         mismatched++;
         $display("FAIL tag_stream_len: got %0d want 5", wq.size());
      end
      for (int i = 0; i < 5; i++) begin
         compared++;
         if (wq[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL tag_stream_byte%0d: got %h want %h", i, wq[i], exp_q[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef TX_RESP_TAG_EN
      test_tag();
`else
      test_alu_only();
      test_rf_only();
      test_round_robin();
      test_backpressure();
      test_reset_midframe();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
